// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, inst} pairs with flush and drop counter.
// Optional same-cycle bypass when empty is enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid,
    input  logic [AW-1:0] if_pc,
    input  logic [DW-1:0] if_inst,
    output logic          if_ready,
    output logic          id_valid,
    output logic [AW-1:0] id_pc,
    output logic [DW-1:0] id_inst,
    input  logic          id_ready,
    input  logic          flush,
    output logic [7:0]    drop_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass;
    logic store;
    logic take;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign if_ready = ~full;

`ifdef IF_ID_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming pair straight to decode.
    assign bypass   = empty & if_valid & ~flush;
    assign id_valid = ~empty | bypass;
    assign id_pc    = ~empty ? pc_mem[rd_ptr]   : (bypass ? if_pc   : '0);
    assign id_inst  = ~empty ? inst_mem[rd_ptr] : (bypass ? if_inst : '0);
`else
    assign bypass   = 1'b0;
    assign id_valid = ~empty;
    assign id_pc    = ~empty ? pc_mem[rd_ptr]   : '0;
    assign id_inst  = ~empty ? inst_mem[rd_ptr] : '0;
`endif

    assign push  = if_valid & if_ready;
    assign pop   = id_valid & id_ready;
    // A bypassed pair consumed the same cycle never touches storage.
    assign store = push & ~(bypass & id_ready);
    assign take  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= sat_add8(drop_cnt, 8'(count) + 8'(push));
        end else begin
            if (store) wr_ptr <= wr_ptr + PW'(1);
            if (take)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(store) - (PW+1)'(take);
        end
    end

    always_ff @(posedge clk) begin
        if (store & ~flush) begin
            pc_mem[wr_ptr]   <= if_pc;
            inst_mem[wr_ptr] <= if_inst;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed table-driven bench for if_id_queue (DEPTH=4), plus reset, drop-counter saturation and bypass sequences.
module tb_if_id_queue;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [DW-1:0] if_inst;
    logic          if_ready;
    logic          id_valid;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_inst;
    logic          id_ready;
    logic          flush;
    logic [7:0]    drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .flush    (flush),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ir;
        logic        fl;
        logic        ev;
        logic [31:0] epc;
        logic        er;
        logic [7:0]  ed;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    function automatic void add(input logic iv, input logic [31:0] pc, input logic ir, input logic fl,
                                input logic ev, input logic [31:0] epc, input logic er, input logic [7:0] ed);
        vec_t v;
        v.iv = iv; v.pc = pc; v.ir = ir; v.fl = fl;
        v.ev = ev; v.epc = epc; v.er = er; v.ed = ed;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic ir, input logic fl);
        if_valid = iv;
        if_pc    = pc;
        if_inst  = inst_of(pc);
        id_ready = ir;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_drop;

    initial begin
        // Fill / drain with refused push when full
        add(1, 32'h00, 0, 0, 0, 32'h00, 1, 0);
        add(1, 32'h04, 0, 0, 1, 32'h00, 1, 0);
        add(1, 32'h08, 0, 0, 1, 32'h00, 1, 0);
        add(1, 32'h0C, 0, 0, 1, 32'h00, 1, 0);
        add(1, 32'h10, 0, 0, 1, 32'h00, 0, 0);
        add(0, 32'h00, 1, 0, 1, 32'h00, 0, 0);
        add(0, 32'h00, 1, 0, 1, 32'h04, 1, 0);
        add(0, 32'h00, 1, 0, 1, 32'h08, 1, 0);
        add(0, 32'h00, 1, 0, 1, 32'h0C, 1, 0);
        add(0, 32'h00, 1, 0, 0, 32'h00, 1, 0);
        // Full with simultaneous push and pop
        add(1, 32'h20, 0, 0, 0, 32'h00, 1, 0);
        add(1, 32'h24, 0, 0, 1, 32'h20, 1, 0);
        add(1, 32'h28, 0, 0, 1, 32'h20, 1, 0);
        add(1, 32'h2C, 0, 0, 1, 32'h20, 1, 0);
        add(1, 32'h30, 1, 0, 1, 32'h20, 0, 0);
        add(0, 32'h00, 0, 0, 1, 32'h24, 1, 0);
        // Flush with count=3 and a push offered
        add(1, 32'h34, 0, 1, 1, 32'h24, 1, 0);
        add(1, 32'h200, 0, 0, 0, 32'h00, 1, 4);
        add(0, 32'h00, 1, 0, 1, 32'h200, 1, 4);
        add(0, 32'h00, 0, 0, 0, 32'h00, 1, 4);
        // Continuous push/pop across pointer wrap
        add(1, 32'h100, 1, 0, 0, 32'h00, 1, 4);
        for (int k = 1; k < 10; k++)
            add(1, 32'h100 + 32'(4 * k), 1, 0, 1, 32'h100 + 32'(4 * (k - 1)), 1, 4);
        add(0, 32'h00, 1, 0, 1, 32'h124, 1, 4);
        add(0, 32'h00, 0, 0, 0, 32'h00, 1, 4);
        // Flush with a pop requested and no push: pop not counted
        add(1, 32'h300, 0, 0, 0, 32'h00, 1, 4);
        add(0, 32'h00, 1, 1, 1, 32'h300, 1, 4);
        add(0, 32'h00, 0, 0, 0, 32'h00, 1, 5);

        rst = 1'b1;
        drive(0, 0, 0, 0);
        #2;
        check("reset id_valid", 32'(id_valid), 32'd0);
        check("reset if_ready", 32'(if_ready), 32'd1);
        check("reset id_pc", id_pc, 32'd0);
        check("reset drop_cnt", 32'(drop_cnt), 32'd0);
        tick();
        rst = 1'b0;

`ifndef IF_ID_QUEUE_BYPASS_EN
        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].pc, vecs[i].ir, vecs[i].fl);
            #1;
            check($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d id_pc", i), id_pc, vecs[i].epc);
            check($sformatf("v%0d id_inst", i), id_inst, vecs[i].ev ? inst_of(vecs[i].epc) : 32'd0);
            check($sformatf("v%0d if_ready", i), 32'(if_ready), 32'(vecs[i].er));
            check($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].ed));
            tick();
        end
`endif

        // Asynchronous reset mid-stream with count=3, overriding a flush
        drive(1, 32'h500, 0, 0); tick();
        drive(1, 32'h504, 0, 0); tick();
        drive(1, 32'h508, 0, 0); tick();
        drive(0, 0, 0, 0);
        #1;
        check("pre-reset id_pc", id_pc, 32'h500);
        rst = 1'b1;
        #1;
        check("async reset id_valid", 32'(id_valid), 32'd0);
        check("async reset if_ready", 32'(if_ready), 32'd1);
        check("async reset id_inst", id_inst, 32'd0);
        check("async reset drop_cnt", 32'(drop_cnt), 32'd0);
        drive(1, 32'h50C, 0, 1);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        check("post-reset id_valid", 32'(id_valid), 32'd0);
        check("post-reset drop_cnt", 32'(drop_cnt), 32'd0);
        tick();
        drive(1, 32'h600, 0, 0); tick();
        drive(0, 0, 1, 0);
        #1;
        check("post-reset push id_valid", 32'(id_valid), 32'd1);
        check("post-reset push id_pc", id_pc, 32'h600);
        tick();

        // Drop counter saturation: each round flushes 3 queued + 1 offered
        exp_drop = 0;
        for (int it = 0; it < 70; it++) begin
            for (int j = 0; j < 3; j++) begin
                drive(1, 32'h700 + 32'(4 * j), 0, 0);
                tick();
            end
            drive(1, 32'h7FC, 0, 1);
            tick();
            exp_drop = (exp_drop + 4 > 255) ? 255 : exp_drop + 4;
            drive(0, 0, 0, 0);
            #1;
            check($sformatf("sat round %0d drop_cnt", it), 32'(drop_cnt), 32'(exp_drop));
            if (it == 0) check("post-flush id_valid", 32'(id_valid), 32'd0);
        end

`ifdef IF_ID_QUEUE_BYPASS_EN
        drive(1, 32'h40, 1, 0);
        if_inst = 32'h24020001;
        #1;
        check("bypass id_valid", 32'(id_valid), 32'd1);
        check("bypass id_pc", id_pc, 32'h40);
        check("bypass id_inst", id_inst, 32'h24020001);
        tick();
        drive(0, 0, 0, 0);
        #1;
        check("bypass consumed id_valid", 32'(id_valid), 32'd0);
        drive(1, 32'h44, 0, 0);
        #1;
        check("bypass stall id_pc", id_pc, 32'h44);
        tick();
        drive(0, 0, 1, 0);
        #1;
        check("bypass stored id_valid", 32'(id_valid), 32'd1);
        check("bypass stored id_pc", id_pc, 32'h44);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two in 2..16.
REQ-002 Parameter AW, default 32, PC width; parameter DW, default 32, instruction width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 if_valid  in  1  fetch stage presents a fetched {pc, inst} pair this cycle.
REQ-006 if_pc  in  AW  address of fetched instruction.
REQ-007 if_inst  in  DW  fetched instruction word.
REQ-008 if_ready  out  1  queue can accept a pair this cycle.
REQ-009 id_valid  out  1  head entry presented to decode.
REQ-010 id_pc  out  AW  head entry address.
REQ-011 id_inst  out  DW  head entry instruction.
REQ-012 id_ready  in  1  decode consumes head this cycle (low = decode stall).
REQ-013 flush  in  1  taken jump resolved in decode; discard all queued and incoming pairs.
REQ-014 drop_cnt  out  8  saturating count of entries discarded by flush since reset.

Function
REQ-015 Push = if_valid & if_ready; pop = id_valid & id_ready; both evaluated at the same rising edge.
REQ-016 if_ready SHALL equal (count != DEPTH); a push offered while full is not accepted even if a pop occurs that cycle.
REQ-017 Storage: circular buffer with write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH) and count (log2(DEPTH)+1 bits).
REQ-018 Push writes {if_pc, if_inst} at write pointer, then advances it; pop advances read pointer.
REQ-019 Count next = count + push - pop; simultaneous push and pop leaves count unchanged.
REQ-020 Entries leave in strict push order; no reordering, duplication or loss except by flush.
REQ-021 id_valid SHALL equal (count != 0) in the non-bypass build.
REQ-022 When id_valid is 0, id_pc and id_inst SHALL be all zeros.
REQ-023 Latency push-to-id_valid: 1 cycle (non-bypass build).
REQ-024 Flush has priority over push and pop: next cycle count=0, both pointers=0, no pop counted, incoming pair discarded.
REQ-025 On flush, drop_cnt increments by the pre-flush count plus 1 if a push was offered that cycle, saturating at 255.
REQ-026 if_ready stays per REQ-016 during flush cycle; decode must ignore id_valid in the flush cycle.
REQ-027 Pop with count=0 and push with count=DEPTH SHALL have no effect on state.

Reset
REQ-028 rst asserted: immediately, without clock, count=0, pointers=0, drop_cnt=0, id_valid=0, id_pc=0, id_inst=0, if_ready=1.
REQ-029 Reset mid-operation discards all entries without incrementing drop_cnt; reset overrides flush.
REQ-030 Storage array contents need not be reset; they SHALL never be observable while invalid.

Configuration
REQ-031 Macro IF_ID_QUEUE_BYPASS_EN defined: when count=0, if_valid=1 and flush=0, id_valid=1 and id_pc/id_inst SHALL equal if_pc/if_inst combinationally; if id_ready=1 that same cycle the pair is consumed and not stored (count stays 0).
REQ-032 Bypass with id_ready=0: pair is stored normally per REQ-018.
REQ-033 Macro not defined: no combinational path from if_* to id_*; REQ-021/REQ-023 hold.

Verification
REQ-034 Reset: rst=1 mid-stream with count=3 -> same-cycle id_valid=0, if_ready=1; after release count=0, drop_cnt=0.
REQ-035 Fill/drain: DEPTH=4, id_ready=0, push pc 0x0,0x4,0x8,0xC -> if_ready=0 after 4th; 5th pc 0x10 refused; then id_ready=1 -> outputs 0x0,0x4,0x8,0xC in order, then id_valid=0.
REQ-036 Wrap: 10 continuous push/pop cycles pc 0x100..0x124 step 4 -> identical sequence at id_pc one cycle later, count steady at 1.
REQ-037 Flush: count=3, flush=1 with if_valid=1 -> next cycle id_valid=0, count=0, drop_cnt=4; following push pc 0x200 appears at id_pc next cycle.
REQ-038 Full + simultaneous pop: count=4, if_valid=1, id_ready=1 -> one pop, push refused, count=3.
REQ-039 Bypass build: empty, if_valid=1 pc 0x40 inst 0x24020001, id_ready=1 -> same cycle id_valid=1, id_pc=0x40, id_inst=0x24020001; next cycle count=0.
